flow_control_ras: RTL and testbench
===================================

Name: flow_control_ras

Overview:
- Parametrised successor to the current 19-bit CPU fetch-redirect logic.
- Resolves the next fetch address from jump, conditional branch (beq/bne), call and return.
- Return addresses are held in a configurable-depth return-address stack (RAS) with an up/down pointer, full/empty status and sticky overflow/underflow flags.
- Sits between decode/register-read and the PC register. Honours a pipeline stall and a flush.

Parameters:
- DATA_W, 19, width of compared register operands.
- ADDR_W, 8, instruction address width.
- DEPTH, 8, RAS entries; power of two, minimum 2.
- TRAP_VEC, 8'hFF (ADDR_W bits), redirect target on stack error (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold: no stack update, no flag update.
- flush  in  1  synchronous stack clear (pointer to 0, error flags kept).
- r1_data  in  DATA_W  first compare operand.
- r3_data  in  DATA_W  second compare operand.
- addri  in  ADDR_W  instruction-encoded target.
- pcp1  in  ADDR_W  PC+1 of the current instruction (return address).
- j, beq, bne, call, ret  in  1 each  decoded control.
- addr_f  out  ADDR_W  next fetch address (combinational).
- redirect  out  1  high when addr_f != pcp1 path (taken control transfer).
- stack_full  out  1  pointer == DEPTH.
- stack_empty  out  1  pointer == 0.
- stack_ovf  out  1  sticky: call while full.
- stack_unf  out  1  sticky: ret while empty.
- depth_cnt  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, async):
  - pointer = 0; all entries = 0.
  - stack_ovf = 0, stack_unf = 0.
  - stack_empty = 1, stack_full = 0, depth_cnt = 0.
- Decision priority (combinational): ret > call > j > beq > bne > sequential.
  - ret: addr_f = top entry (entry[ptr-1]); redirect = 1. If empty: addr_f = pcp1, redirect = 0.
  - call: addr_f = addri; redirect = 1.
  - j: addr_f = addri; redirect = 1.
  - beq: taken iff r1_data == r3_data over the full DATA_W bits.
  - bne: taken iff r1_data != r3_data.
  - Taken branch: addr_f = addri, redirect = 1. Not taken: addr_f = pcp1, redirect = 0.
  - None asserted: addr_f = pcp1, redirect = 0.
- Stack update at rising clk, only when stall = 0 and flush = 0:
  - call, not full: entry[ptr] <= pcp1; ptr <= ptr + 1.
  - call, full: no write, ptr unchanged, stack_ovf <= 1.
  - ret, not empty: ptr <= ptr - 1.
  - ret, empty: ptr unchanged, stack_unf <= 1.
  - call and ret together: ret wins (pop only, pcp1 not pushed).
- Write latency: a pushed address becomes visible as top on the next cycle. A ret in the cycle after a call returns that call's pcp1.
- flush = 1 (stall = 0): ptr <= 0 regardless of call/ret. Entry contents and sticky flags are untouched. flush has priority over push/pop.
- stall = 1: stack, pointer and flags hold. addr_f/redirect still evaluate combinationally. flush is ignored while stalled.
- Sticky flags clear only on reset.
- Pointer never wraps; it saturates at 0 and at DEPTH.
- Reset asserted mid-operation clears state immediately; the first edge after deassertion behaves as from empty.

Optional Feature:
- Macro: FLOW_CONTROL_RAS_TRAP_EN.
- Defined:
  - call while full, or ret while empty, forces addr_f = TRAP_VEC and redirect = 1 in that cycle.
  - Output port trap (1 bit) is asserted in that cycle, combinational, masked by stall.
- Not defined:
  - No trap port.
  - Errors only set the sticky flags; addr_f follows the rules in Behaviour.

Test Plan:
- Reset, then beq with r1_data = r3_data = 19'h12345, addri = 8'h40, pcp1 = 8'h11 -> addr_f = 8'h40, redirect = 1. Set r3_data = 19'h12344 -> addr_f = 8'h11, redirect = 0.
- call pcp1 = 8'h21, addri = 8'h80; next cycle call pcp1 = 8'h81, addri = 8'hA0; next cycle ret -> addr_f = 8'h81; following ret -> addr_f = 8'h21; then stack_empty = 1, depth_cnt = 0.
- DEPTH+1 calls with DEPTH = 8 -> after 8, stack_full = 1; 9th leaves depth_cnt = 8 and sets stack_ovf = 1. Ret then returns the 8th pushed address.
- ret on empty with pcp1 = 8'h05 -> addr_f = 8'h05, stack_unf = 1, ptr stays 0. With FLOW_CONTROL_RAS_TRAP_EN defined -> addr_f = 8'hFF, trap = 1.
- Push 3 entries, assert stall with call -> depth_cnt stays 3. Deassert stall, assert flush with call -> depth_cnt = 0 next cycle, sticky flags unchanged.
- Assert call and ret together with depth 2 -> addr_f = previous top, depth_cnt = 1. Drop rst_n mid-sequence -> all status outputs at reset values without a clock edge.

Source files
------------

// File: rtl/flow_control_ras.sv
// Next-fetch-address resolver with a return-address stack (RAS) for call/ret.
// Optional trap redirect on stack over/underflow: define FLOW_CONTROL_RAS_TRAP_EN.
module flow_control_ras #(
    parameter int                DATA_W   = 19,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 8,
    parameter logic [ADDR_W-1:0] TRAP_VEC = {ADDR_W{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          r1_data,
    input  logic [DATA_W-1:0]          r3_data,
    input  logic [ADDR_W-1:0]          addri,
    input  logic [ADDR_W-1:0]          pcp1,
    input  logic                       j,
    input  logic                       beq,
    input  logic                       bne,
    input  logic                       call,
    input  logic                       ret,
    output logic [ADDR_W-1:0]          addr_f,
    output logic                       redirect,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_ovf,
    output logic                       stack_unf,
    output logic [$clog2(DEPTH):0]     depth_cnt
`ifdef FLOW_CONTROL_RAS_TRAP_EN
    ,
    output logic                       trap
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

`ifdef FLOW_CONTROL_RAS_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] entries [DEPTH];
    logic [PW-1:0]     ptr;
    logic [IW-1:0]     top_idx;
    logic              full;
    logic              empty;
    logic              ops_equal;
    logic              ovf_hit;
    logic              unf_hit;
    logic              err_now;

    assign full      = (ptr == PW'(DEPTH));
    assign empty     = (ptr == '0);
    assign top_idx   = IW'(ptr - PW'(1));
    assign ops_equal = (r1_data == r3_data);

    // ret outranks call, so a simultaneous call never counts as an overflow
    assign ovf_hit = call & ~ret & full;
    assign unf_hit = ret & empty;
    assign err_now = (ovf_hit | unf_hit) & ~stall;

`ifdef FLOW_CONTROL_RAS_TRAP_EN
    assign trap = err_now;
`endif

    always_comb begin
        addr_f   = pcp1;
        redirect = 1'b0;
        if (ret) begin
            if (!empty) begin
                addr_f   = entries[top_idx];
                redirect = 1'b1;
            end
        end else if (call || j) begin
            addr_f   = addri;
            redirect = 1'b1;
        end else if (beq) begin
            if (ops_equal) begin
                addr_f   = addri;
                redirect = 1'b1;
            end
        end else if (bne) begin
            if (!ops_equal) begin
                addr_f   = addri;
                redirect = 1'b1;
            end
        end
        if (TRAP_EN && err_now) begin
            addr_f   = TRAP_VEC;
            redirect = 1'b1;
        end
    end

    // flush only rewinds the pointer; stale entries become unreachable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (!stall) begin
            if (flush) begin
                ptr <= '0;
            end else if (ret) begin
                if (empty) begin
                    stack_unf <= 1'b1;
                end else begin
                    ptr <= ptr - PW'(1);
                end
            end else if (call) begin
                if (full) begin
                    stack_ovf <= 1'b1;
                end else begin
                    entries[ptr[IW-1:0]] <= pcp1;
                    ptr                  <= ptr + PW'(1);
                end
            end
        end
    end

    assign stack_full  = full;
    assign stack_empty = empty;
    assign depth_cnt   = ptr;

endmodule

// File: tb/tb_flow_control_ras.sv
// Bench for flow_control_ras: queue-based reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_flow_control_ras;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;
    localparam int PW     = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] TRAP_VEC = 8'hFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              stall, flush, j, beq, bne, call, ret;
    logic [DATA_W-1:0] r1_data, r3_data;
    logic [ADDR_W-1:0] addri, pcp1;
    logic [ADDR_W-1:0] addr_f;
    logic              redirect, stack_full, stack_empty, stack_ovf, stack_unf;
    logic [PW-1:0]     depth_cnt;
`ifdef FLOW_CONTROL_RAS_TRAP_EN
    logic              trap;
    localparam bit     TRAP_ON = 1'b1;
`else
    localparam bit     TRAP_ON = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    flow_control_ras #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TRAP_VEC(TRAP_VEC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .r1_data(r1_data), .r3_data(r3_data), .addri(addri), .pcp1(pcp1),
        .j(j), .beq(beq), .bne(bne), .call(call), .ret(ret),
        .addr_f(addr_f), .redirect(redirect),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf), .depth_cnt(depth_cnt)
`ifdef FLOW_CONTROL_RAS_TRAP_EN
        , .trap(trap)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue is the stack, plus two sticky bits
    logic [ADDR_W-1:0] m_stk[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!stall) begin
            if (flush) m_stk.delete();
            else if (ret) begin
                if (m_stk.size() == 0) m_unf = 1;
                else void'(m_stk.pop_back());
            end else if (call) begin
                if (m_stk.size() == DEPTH) m_ovf = 1;
                else m_stk.push_back(pcp1);
            end
        end
    end

    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        logic er, et;
        ea = pcp1; er = 0; et = 0;
        if (ret) begin
            if (m_stk.size() != 0) begin ea = m_stk[m_stk.size()-1]; er = 1; end
            else et = !stall;
        end else if (call) begin
            ea = addri; er = 1;
            et = (m_stk.size() == DEPTH) && !stall;
        end else if (j) begin
            ea = addri; er = 1;
        end else if (beq) begin
            if (r1_data == r3_data) begin ea = addri; er = 1; end
        end else if (bne) begin
            if (r1_data != r3_data) begin ea = addri; er = 1; end
        end
        if (TRAP_ON && et) begin ea = TRAP_VEC; er = 1; end
        check("mdl_addr_f",   addr_f,      ea);
        check("mdl_redirect", redirect,    er);
        check("mdl_depth",    depth_cnt,   m_stk.size());
        check("mdl_full",     stack_full,  m_stk.size() == DEPTH);
        check("mdl_empty",    stack_empty, m_stk.size() == 0);
        check("mdl_ovf",      stack_ovf,   m_ovf);
        check("mdl_unf",      stack_unf,   m_unf);
`ifdef FLOW_CONTROL_RAS_TRAP_EN
        check("mdl_trap",     trap,        et);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 0; flush = 0; j = 0; beq = 0; bne = 0; call = 0; ret = 0;
    endtask

    initial begin
        clr();
        r1_data = '0; r3_data = '0; addri = '0; pcp1 = '0;
        #1 rst_n = 0;
        #2;
        check("rst_empty", stack_empty, 1);
        check("rst_full",  stack_full,  0);
        check("rst_depth", depth_cnt,   0);
        check("rst_ovf",   stack_ovf,   0);
        check("rst_unf",   stack_unf,   0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // branches
        beq = 1; r1_data = 19'h12345; r3_data = 19'h12345; addri = 8'h40; pcp1 = 8'h11;
        #1;
        check("beq_taken_addr", addr_f, 8'h40);
        check("beq_taken_red",  redirect, 1);
        r3_data = 19'h12344;
        #1;
        check("beq_nt_addr", addr_f, 8'h11);
        check("beq_nt_red",  redirect, 0);
        beq = 0; bne = 1;
        #1;
        check("bne_taken_addr", addr_f, 8'h40);
        r3_data = 19'h12345;
        #1;
        check("bne_nt_addr", addr_f, 8'h11);
        bne = 0; j = 1; addri = 8'h9C;
        #1;
        check("j_addr", addr_f, 8'h9C);
        step();

        // nested call / ret
        clr(); call = 1; pcp1 = 8'h21; addri = 8'h80;
        #1 check("call1_addr", addr_f, 8'h80);
        step();
        pcp1 = 8'h81; addri = 8'hA0;
        step();
        call = 0; ret = 1;
        #1 check("ret1_addr", addr_f, 8'h81);
        step();
        check("ret2_addr", addr_f, 8'h21);
        step();
        ret = 0;
        check("pop_empty", stack_empty, 1);
        check("pop_depth", depth_cnt, 0);

        // fill and overflow
        call = 1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            pcp1 = 8'h30 + 8'(i);
            step();
            if (i == DEPTH - 1) begin
                check("fill_full",  stack_full, 1);
                check("fill_depth", depth_cnt, 8);
            end
        end
        check("ovf_depth", depth_cnt, 8);
        check("ovf_flag",  stack_ovf, 1);
        call = 0; ret = 1;
        #1 check("ovf_ret_addr", addr_f, 8'h37);
        step();
        check("ovf_ret_depth", depth_cnt, 7);
        repeat (7) step();
        ret = 0;
        check("drain_empty", stack_empty, 1);

        // underflow
        ret = 1; pcp1 = 8'h05;
        #1;
`ifdef FLOW_CONTROL_RAS_TRAP_EN
        check("unf_addr", addr_f, 8'hFF);
        check("unf_trap", trap, 1);
`else
        check("unf_addr", addr_f, 8'h05);
`endif
        step();
        ret = 0;
        check("unf_flag",  stack_unf, 1);
        check("unf_depth", depth_cnt, 0);

        // stall and flush
        call = 1;
        for (int i = 0; i < 3; i++) begin pcp1 = 8'h50 + 8'(i); step(); end
        stall = 1; pcp1 = 8'h53; addri = 8'hC0;
        #1 check("stall_addr", addr_f, 8'hC0);
        step();
        check("stall_depth", depth_cnt, 3);
        stall = 0; flush = 1;
        step();
        flush = 0;
        check("flush_depth", depth_cnt, 0);
        check("flush_ovf",   stack_ovf, 1);
        check("flush_unf",   stack_unf, 1);

        // call+ret together, then async reset mid-cycle
        pcp1 = 8'h60; step();
        pcp1 = 8'h61; step();
        ret = 1; pcp1 = 8'h62;
        #1 check("cr_addr", addr_f, 8'h61);
        step();
        check("cr_depth", depth_cnt, 1);
        ret = 0; pcp1 = 8'h70;
        #2 rst_n = 0;
        #1;
        check("arst_empty", stack_empty, 1);
        check("arst_depth", depth_cnt, 0);
        check("arst_ovf",   stack_ovf, 0);
        check("arst_unf",   stack_unf, 0);
        check("arst_full",  stack_full, 0);
        @(posedge clk);
        #1 rst_n = 1;
        pcp1 = 8'h90;
        step();
        check("post_rst_depth", depth_cnt, 1);
        call = 0; ret = 1;
        #1 check("post_rst_ret", addr_f, 8'h90);
        step();
        clr();
        check("final_empty", stack_empty, 1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
